// File: rtl/param_cu.sv
// param_cu: operand-resolving control unit driving an external ALU over req/done.
// Define PARAM_CU_RETIRE_CNT_EN to add the RETIRED writeback counter output.
module param_cu #(
    parameter int DATA_W    = 16,
    parameter int NUM_REGS  = 8,
    parameter int NUM_OPNDS = 4,
    parameter int OPND_W    = 8,
    parameter int OPC_W     = 9,
    parameter int TIMEOUT   = 255,
    localparam int RIDX_W   = $clog2(NUM_REGS),
    localparam int INSTR_W  = OPC_W + NUM_OPNDS*(1+OPND_W) + RIDX_W
) (
    input  logic                          CLK,
    input  logic                          RST_N,
    input  logic                          INSTR_VALID,
    output logic                          INSTR_READY,
    input  logic [INSTR_W-1:0]            INSTRUCTION,
    output logic                          ALU_REQ,
    output logic [OPC_W-1:0]              ALU_OPCODES,
    output logic [NUM_OPNDS*OPND_W-1:0]   ALU_OPRANDS,
    input  logic                          ALU_DONE,
    input  logic [DATA_W-1:0]             ALU_OUT,
    output logic [NUM_REGS*DATA_W-1:0]    REGISTER_OUTPUT_DATA_BUS,
    output logic                          BUSY,
    input  logic                          ERR_CLR,
`ifdef PARAM_CU_RETIRE_CNT_EN
    output logic [15:0]                   RETIRED,
`endif
    output logic [1:0]                    ERR
);

    localparam int FLD_W = 1 + OPND_W;
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC} state_t;

    state_t                        state_q, state_d;
    logic [INSTR_W-1:0]            instr_q, instr_d;
    logic [OPC_W-1:0]              opc_q, opc_d;
    logic [NUM_OPNDS*OPND_W-1:0]   opr_q, opr_d;
    logic                          req_q, req_d;
    logic [CNT_W-1:0]              cnt_q, cnt_d;
    logic [DATA_W-1:0]             regs_q [NUM_REGS];
    logic [DATA_W-1:0]             regs_d [NUM_REGS];
    logic [1:0]                    err_q, err_d, err_set;
`ifdef PARAM_CU_RETIRE_CNT_EN
    logic [15:0]                   retired_q, retired_d;
`endif

    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        opc_d   = opc_q;
        opr_d   = opr_q;
        req_d   = req_q;
        cnt_d   = cnt_q;
        regs_d  = regs_q;
        err_set = '0;
`ifdef PARAM_CU_RETIRE_CNT_EN
        retired_d = retired_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (INSTR_VALID) begin
                    instr_d = INSTRUCTION;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                for (int k = 0; k < NUM_OPNDS; k++) begin
                    logic [FLD_W-1:0]  fld;
                    logic [OPND_W-1:0] val;
                    logic [OPND_W-1:0] opnd;
                    fld  = instr_q[RIDX_W + (NUM_OPNDS-1-k)*FLD_W +: FLD_W];
                    val  = fld[OPND_W-1:0];
                    opnd = val;
                    if (fld[OPND_W]) begin
                        // out-of-range sources read as zero and flag
                        if ((val >> RIDX_W) == '0) begin
                            opnd = regs_q[val[RIDX_W-1:0]][OPND_W-1:0];
                        end else begin
                            opnd       = '0;
                            err_set[0] = 1'b1;
                        end
                    end
                    opr_d[(NUM_OPNDS-1-k)*OPND_W +: OPND_W] = opnd;
                end
                opc_d   = instr_q[INSTR_W-1 -: OPC_W];
                cnt_d   = '0;
                req_d   = 1'b1;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                if (ALU_DONE) begin
                    regs_d[instr_q[RIDX_W-1:0]] = ALU_OUT;
                    req_d   = 1'b0;
                    state_d = S_IDLE;
`ifdef PARAM_CU_RETIRE_CNT_EN
                    retired_d = retired_q + 16'd1;
`endif
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    err_set[1] = 1'b1;
                    req_d      = 1'b0;
                    state_d    = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                req_d   = 1'b0;
                state_d = S_IDLE;
            end
        endcase
        err_d = (ERR_CLR ? 2'b00 : err_q) | err_set;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            instr_q <= '0;
            opc_q   <= '0;
            opr_q   <= '0;
            req_q   <= 1'b0;
            cnt_q   <= '0;
            err_q   <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
`ifdef PARAM_CU_RETIRE_CNT_EN
            retired_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            opc_q   <= opc_d;
            opr_q   <= opr_d;
            req_q   <= req_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
`ifdef PARAM_CU_RETIRE_CNT_EN
            retired_q <= retired_d;
`endif
        end
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_bus
        assign REGISTER_OUTPUT_DATA_BUS[i*DATA_W +: DATA_W] = regs_q[i];
    end

    assign INSTR_READY = (state_q == S_IDLE);
    assign BUSY        = (state_q != S_IDLE);
    assign ALU_REQ     = req_q;
    assign ALU_OPCODES = opc_q;
    assign ALU_OPRANDS = opr_q;
    assign ERR         = err_q;
`ifdef PARAM_CU_RETIRE_CNT_EN
    assign RETIRED     = retired_q;
`endif

endmodule

// File: tb/tb_param_cu.sv
// Scoreboard bench for param_cu at default parameters.
// Issue and writeback expectations are queued by stimulus, popped by the monitor.
module tb_param_cu;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         instr_valid;
    logic         instr_ready;
    logic [47:0]  instruction;
    logic         alu_req;
    logic [8:0]   alu_opcodes;
    logic [31:0]  alu_oprands;
    logic         alu_done;
    logic [15:0]  alu_out;
    logic [127:0] bus;
    logic         busy;
    logic         err_clr;
    logic [1:0]   err;
`ifdef PARAM_CU_RETIRE_CNT_EN
    logic [15:0]  retired;
`endif

    param_cu dut (
        .CLK(clk),
        .RST_N(rst_n),
        .INSTR_VALID(instr_valid),
        .INSTR_READY(instr_ready),
        .INSTRUCTION(instruction),
        .ALU_REQ(alu_req),
        .ALU_OPCODES(alu_opcodes),
        .ALU_OPRANDS(alu_oprands),
        .ALU_DONE(alu_done),
        .ALU_OUT(alu_out),
        .REGISTER_OUTPUT_DATA_BUS(bus),
        .BUSY(busy),
        .ERR_CLR(err_clr),
`ifdef PARAM_CU_RETIRE_CNT_EN
        .RETIRED(retired),
`endif
        .ERR(err)
    );

    always #5 clk = ~clk;

    typedef struct { int dst; logic [15:0] val; } wb_t;

    logic [40:0] exp_alu[$];
    wb_t         exp_wb[$];
    logic [15:0] alu_vals[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int wb_cyc = -1;
    int acc_cyc = -1;
    logic wb_seen = 1'b0;
    logic alu_hang = 1'b0;
    int   alu_delay = 2;

    task automatic check(input string nm, input logic [127:0] act,
                         input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [47:0] mk(input logic [8:0] opc,
        input logic [3:0] m, input logic [7:0] v0, input logic [7:0] v1,
        input logic [7:0] v2, input logic [7:0] v3, input logic [2:0] d);
        return {opc, m[3], v0, m[2], v1, m[1], v2, m[0], v3, d};
    endfunction

    task automatic send(input logic [47:0] ins, input logic [31:0] eopr,
                        input logic do_wb, input logic [15:0] wval);
        int n = 0;
        wb_t w;
        exp_alu.push_back({ins[47:39], eopr});
        if (do_wb) begin
            w.dst = int'(ins[2:0]);
            w.val = wval;
            exp_wb.push_back(w);
            alu_vals.push_back(wval);
        end
        instr_valid = 1'b1;
        instruction = ins;
        while (!instr_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) check("accept_timeout", 1, 0);
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        instr_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) check("idle_timeout", 1, 0);
    endtask

    // ALU model: answers req after alu_delay negedges, one-cycle done pulse
    initial begin
        int cnt = 0;
        alu_done = 1'b0;
        alu_out  = '0;
        forever begin
            @(negedge clk);
            if (alu_done) begin
                alu_done = 1'b0;
                cnt = 0;
            end else if (rst_n && alu_req && !alu_hang) begin
                if (cnt >= alu_delay) begin
                    alu_done = 1'b1;
                    if (alu_vals.size() > 0) alu_out = alu_vals.pop_front();
                    else alu_out = 16'hDEAD;
                    cnt = 0;
                end else begin
                    cnt++;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    always @(posedge clk) begin
        cyc++;
        if (rst_n && alu_req && alu_done) begin
            wb_seen = 1'b1;
            wb_cyc  = cyc;
        end
    end

    // monitor
    initial begin
        logic req_prev = 1'b0;
        logic [40:0] ea;
        wb_t w;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                req_prev = 1'b0;
                wb_seen  = 1'b0;
            end else begin
                if (alu_req && !req_prev) begin
                    if (exp_alu.size() == 0) begin
                        check("unexpected_issue", 1, 0);
                    end else begin
                        ea = exp_alu.pop_front();
                        check("alu_opcode", alu_opcodes, ea[40:32]);
                        check("alu_oprands", alu_oprands, ea[31:0]);
                    end
                end
                req_prev = alu_req;
                if (wb_seen) begin
                    wb_seen = 1'b0;
                    if (exp_wb.size() == 0) begin
                        check("unexpected_wb", 1, 0);
                    end else begin
                        w = exp_wb.pop_front();
                        check("wb_reg", bus[w.dst*16 +: 16], w.val);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int k;
        int req_at;
        int wb_a;
        rst_n = 1'b0;
        instr_valid = 1'b0;
        instruction = '0;
        err_clr = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready", instr_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_req", alu_req, 0);
        check("rst_opc", alu_opcodes, 0);
        check("rst_opr", alu_oprands, 0);
        check("rst_err", err, 0);
        check("rst_bus", bus, 0);

        // 1: immediates, req latency and busy length
        alu_delay = 2;
        send(mk(9'h001, 4'b0000, 8'd3, 8'd4, 8'd0, 8'd0, 3'd2),
             32'h03040000, 1'b1, 16'h0007);
        n = 0;
        req_at = -1;
        @(negedge clk);
        while (busy && n < 400) begin
            n++;
            if (alu_req && req_at < 0) req_at = n;
            @(negedge clk);
        end
        check("busy_cycles", n, 4);
        check("req_latency", req_at, 2);
        check("bus_reg2", bus[47:32], 16'h0007);

        // 2: register source, truncated to low byte
        send(mk(9'h002, 4'b0000, 8'd0, 8'd0, 8'd0, 8'd0, 3'd1),
             32'h00000000, 1'b1, 16'h1234);
        wait_idle();
        send(mk(9'h003, 4'b1000, 8'd1, 8'd0, 8'd0, 8'd0, 3'd5),
             32'h34000000, 1'b1, 16'hABCD);
        wait_idle();

        // 3: illegal source index still executes
        send(mk(9'h0A5, 4'b0110, 8'h55, 8'd9, 8'd2, 8'hFF, 3'd6),
             32'h550007FF, 1'b1, 16'h0BAD);
        wait_idle();
        check("err_illegal", err, 2'b01);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("err_clr", err, 2'b00);

        // 4: timeout
        alu_hang = 1'b1;
        send(mk(9'h004, 4'b0000, 8'd1, 8'd1, 8'd1, 8'd1, 3'd4),
             32'h01010101, 1'b0, 16'h0);
        n = 0;
        k = 0;
        while (k < 400) begin
            @(negedge clk);
            if (alu_req) n++;
            else if (n > 0) break;
            k++;
        end
        check("exec_cycles", n, 255);
        check("to_err", err, 2'b10);
        check("to_ready", instr_ready, 1);
        check("to_reg4", bus[79:64], 16'h0000);
        check("to_reg6", bus[111:96], 16'h0BAD);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;

        // 5: async reset mid-EXEC
        send(mk(9'h005, 4'b0000, 8'd2, 8'd2, 8'd2, 8'd2, 3'd7),
             32'h02020202, 1'b1, 16'h7777);
        n = 0;
        while (!alu_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("pre_rst_req", alu_req, 1);
        #2;
        rst_n = 1'b0;
        instr_valid = 1'b1;
        instruction = mk(9'h1FF, 4'b0000, 8'd1, 8'd1, 8'd1, 8'd1, 3'd1);
        #1;
        check("rst_async_req", alu_req, 0);
        check("rst_async_bus", bus, 0);
        repeat (2) @(negedge clk);
        check("rst_hold_busy", busy, 0);
        exp_wb.delete();
        alu_vals.delete();
        alu_hang = 1'b0;
        instr_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_busy", busy, 0);
        check("post_rst_err", err, 0);

        // 6: back-to-back dependent instructions
        alu_delay = 0;
        send(mk(9'h006, 4'b0000, 8'd0, 8'd0, 8'd0, 8'd0, 3'd3),
             32'h00000000, 1'b1, 16'h0010);
        send(mk(9'h007, 4'b1000, 8'd3, 8'd1, 8'd2, 8'd3, 3'd0),
             32'h10010203, 1'b1, 16'h4321);
        wb_a = wb_cyc;
        check("b2b_accept", acc_cyc, wb_a + 1);
        wait_idle();
        check("b2b_reg3", bus[63:48], 16'h0010);
        check("b2b_reg0", bus[15:0], 16'h4321);
`ifdef PARAM_CU_RETIRE_CNT_EN
        check("retired", retired, 16'd2);
`endif
        repeat (2) @(negedge clk);
        check("sb_alu_empty", exp_alu.size(), 0);
        check("sb_wb_empty", exp_wb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
